// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings, slave state enum and lane/alignment helpers.
// Combinational helpers only; no state or flow control lives here.
package ahb_pkg;

   localparam logic [1:0] HTRANS_IDLE   = 2'b00;
   localparam logic [1:0] HTRANS_BUSY   = 2'b01;
   localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
   localparam logic [1:0] HTRANS_SEQ    = 2'b11;

   localparam logic [2:0] HSIZE_BYTE = 3'd0;
   localparam logic [2:0] HSIZE_HALF = 3'd1;
   localparam logic [2:0] HSIZE_WORD = 3'd2;

   localparam logic HRESP_OKAY  = 1'b0;
   localparam logic HRESP_ERROR = 1'b1;

   typedef enum logic [1:0] {
      S_IDLE,
      S_WAIT,
      S_ERR1,
      S_ERR2
   } slv_state_e;

   // Little-endian byte enables for a transfer of the given size at byte offset a.
   function automatic logic [3:0] lane_be(input logic [2:0] size, input logic [1:0] a);
      logic [3:0] be;
      be = 4'b1111;
      if (size == HSIZE_BYTE)      be = 4'b0001 << a;
      else if (size == HSIZE_HALF) be = a[1] ? 4'b1100 : 4'b0011;
      return be;
   endfunction

   function automatic logic is_misaligned(input logic [2:0] size, input logic [1:0] a);
      return (size > HSIZE_WORD) ||
             ((size == HSIZE_HALF) && a[0]) ||
             ((size == HSIZE_WORD) && (a != 2'b00));
   endfunction

endpackage

// File: rtl/ahb_mem_array.sv
// Word-wide storage with per-byte write enables, write on posedge, asynchronous read.
// Contents are deliberately not reset.
module ahb_mem_array #(
   parameter int DEPTH = 1024,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic          clk_i,
   input  logic [3:0]    we_i,
   input  logic [AW-1:0] addr_i,
   input  logic [31:0]   wdata_i,
   output logic [31:0]   rdata_o
);

   logic [31:0] mem_q [DEPTH];

   always_ff @(posedge clk_i) begin
      for (int b = 0; b < 4; b++) begin
         if (we_i[b]) mem_q[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
      end
   end

   assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/ahb_mem_slave.sv
// AHB-Lite memory slave: OKAY data phase completes WAIT_STATES+1 cycles after address acceptance,
// illegal accesses get a two-cycle ERROR; hreadyout is low during wait states and the first error cycle.
module ahb_mem_slave
   import ahb_pkg::*;
#(
   parameter int ADDR_W      = 16,
   parameter int DATA_W      = 32,
   parameter int MEM_DEPTH   = 1024,
   parameter int WAIT_STATES = 0
) (
   input  logic              hclk,
   input  logic              hresetn,
   input  logic              hselx,
   input  logic [ADDR_W-1:0] haddr,
   input  logic [1:0]        htrans,
   input  logic              hwrite,
   input  logic [2:0]        hsize,
   input  logic              hready,
   input  logic [DATA_W-1:0] hwdata,
   output logic [DATA_W-1:0] hrdata,
   output logic              hreadyout,
   output logic              hresp
);

   localparam int         AW      = $clog2(MEM_DEPTH);
   localparam logic [3:0] WS_LOAD = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

   slv_state_e        state_q, state_d;
   logic [3:0]        cnt_q, cnt_d;
   logic              dph_q, dph_d;
   logic [AW+1:0]     addr_q, addr_d;
   logic              hwrite_q, hwrite_d;
   logic [2:0]        hsize_q, hsize_d;

   logic              ready_int;
   logic              accept;
   logic              illegal;
   logic [ADDR_W-3:0] widx;
   logic [3:0]        be;
   logic [31:0]       mem_rdata;

   assign widx      = haddr[ADDR_W-1:2];
   assign illegal   = (32'(widx) >= 32'(MEM_DEPTH)) || is_misaligned(hsize, haddr[1:0]);
   assign ready_int = (state_q == S_IDLE) || (state_q == S_ERR2);
   // Gating with our own ready keeps a misbehaving master from slipping a transfer in mid-stall.
   assign accept    = hselx && hready && ready_int &&
                      ((htrans == HTRANS_NONSEQ) || (htrans == HTRANS_SEQ));

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      dph_d    = dph_q;
      addr_d   = addr_q;
      hwrite_d = hwrite_q;
      hsize_d  = hsize_q;
      case (state_q)
         S_WAIT: begin
            if (cnt_q == 4'd0) state_d = S_IDLE;
            else               cnt_d   = cnt_q - 4'd1;
         end
         S_ERR1: state_d = S_ERR2;
         default: begin
            state_d = S_IDLE;
            dph_d   = 1'b0;
            if (accept) begin
               addr_d   = haddr[AW+1:0];
               hwrite_d = hwrite;
               hsize_d  = hsize;
               if (illegal) begin
                  state_d = S_ERR1;
               end else begin
                  dph_d = 1'b1;
                  if (WAIT_STATES != 0) begin
                     state_d = S_WAIT;
                     cnt_d   = WS_LOAD;
                  end
               end
            end
         end
      endcase
   end

   always_ff @(posedge hclk or negedge hresetn) begin
      if (!hresetn) begin
         state_q  <= S_IDLE;
         cnt_q    <= '0;
         dph_q    <= 1'b0;
         addr_q   <= '0;
         hwrite_q <= 1'b0;
         hsize_q  <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         dph_q    <= dph_d;
         addr_q   <= addr_d;
         hwrite_q <= hwrite_d;
         hsize_q  <= hsize_d;
      end
   end

   // dph_q is only ever set for legal transfers, so ERROR phases can never write.
   assign be = (dph_q && hwrite_q && (state_q == S_IDLE)) ? lane_be(hsize_q, addr_q[1:0]) : 4'b0000;

   ahb_mem_array #(
      .DEPTH (MEM_DEPTH),
      .AW    (AW)
   ) u_mem (
      .clk_i   (hclk),
      .we_i    (be),
      .addr_i  (addr_q[AW+1:2]),
      .wdata_i (hwdata),
      .rdata_o (mem_rdata)
   );

   assign hreadyout = ready_int;
   assign hresp     = ((state_q == S_ERR1) || (state_q == S_ERR2)) ? HRESP_ERROR : HRESP_OKAY;
   assign hrdata    = (dph_q && !hwrite_q) ? mem_rdata : '0;

endmodule

// File: tb/tb_ahb_mem_slave.sv
// Bench for ahb_mem_slave: two instances (0 and 3 wait states) driven by a pipelined master,
// with expected completions queued at issue time and checked by a separate bus monitor.
module tb_ahb_mem_slave;
   import ahb_pkg::*;

   typedef struct packed {
      logic        err;
      logic        rd;
      logic [31:0] rdata;
      logic [3:0]  nlow;
   } exp_t;

   logic        hclk;
   logic        hresetn   [2];
   logic        hselx     [2];
   logic [15:0] haddr     [2];
   logic [1:0]  htrans    [2];
   logic        hwrite    [2];
   logic [2:0]  hsize     [2];
   logic [31:0] hwdata    [2];
   logic [31:0] hrdata    [2];
   logic        hreadyout [2];
   logic        hresp     [2];

   exp_t q0[$];
   exp_t q1[$];
   int   n_chk  = 0;
   int   n_fail = 0;

   logic       dph_m   [2];
   logic [3:0] nlow_m  [2];
   logic       lores_m [2];

   ahb_mem_slave #(.ADDR_W(16), .DATA_W(32), .MEM_DEPTH(1024), .WAIT_STATES(0)) u_dut0 (
      .hclk(hclk), .hresetn(hresetn[0]), .hselx(hselx[0]), .haddr(haddr[0]),
      .htrans(htrans[0]), .hwrite(hwrite[0]), .hsize(hsize[0]), .hready(hreadyout[0]),
      .hwdata(hwdata[0]), .hrdata(hrdata[0]), .hreadyout(hreadyout[0]), .hresp(hresp[0])
   );

   ahb_mem_slave #(.ADDR_W(16), .DATA_W(32), .MEM_DEPTH(1024), .WAIT_STATES(3)) u_dut1 (
      .hclk(hclk), .hresetn(hresetn[1]), .hselx(hselx[1]), .haddr(haddr[1]),
      .htrans(htrans[1]), .hwrite(hwrite[1]), .hsize(hsize[1]), .hready(hreadyout[1]),
      .hwdata(hwdata[1]), .hrdata(hrdata[1]), .hreadyout(hreadyout[1]), .hresp(hresp[1])
   );

   initial begin
      hclk = 1'b0;
      forever #5 hclk = ~hclk;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic push(input int d, input exp_t e);
      if (d == 0) q0.push_back(e);
      else        q1.push_back(e);
   endtask

   // Holds the current address phase until the slave is ready, then advances one edge.
   task automatic wait_accept(input int d);
      logic ok;
      int   n;
      n = 0;
      do begin
         ok = hreadyout[d];
         @(posedge hclk);
         #1;
         n++;
      end while (!ok && n < 40);
      chk($sformatf("d%0d_accept_in_time", d), 32'(ok), 32'd1);
   endtask

   task automatic xfer(input int d, input logic sel, input logic [1:0] tr, input logic [15:0] a,
                       input logic wr, input logic [2:0] sz, input logic [31:0] wd,
                       input logic eerr, input logic [31:0] erd);
      exp_t e;
      hselx[d]  = sel;
      htrans[d] = tr;
      haddr[d]  = a;
      hwrite[d] = wr;
      hsize[d]  = sz;
      if (sel && tr[1]) begin
         e.err   = eerr;
         e.rd    = !wr;
         e.rdata = erd;
         e.nlow  = eerr ? 4'd1 : ((d == 1) ? 4'd3 : 4'd0);
         push(d, e);
      end
      wait_accept(d);
      if (wr) hwdata[d] = wd;
      hselx[d]  = 1'b0;
      htrans[d] = HTRANS_IDLE;
   endtask

   task automatic idle(input int d);
      hselx[d]  = 1'b0;
      htrans[d] = HTRANS_IDLE;
      wait_accept(d);
   endtask

   always @(negedge hclk) begin
      exp_t e;
      for (int d = 0; d < 2; d++) begin
         if (!hresetn[d]) begin
            dph_m[d]   = 1'b0;
            nlow_m[d]  = 4'd0;
            lores_m[d] = 1'b0;
            if (d == 0) q0.delete();
            else        q1.delete();
         end else begin
            if (dph_m[d]) begin
               if (!hreadyout[d]) begin
                  nlow_m[d]  = nlow_m[d] + 4'd1;
                  lores_m[d] = lores_m[d] | hresp[d];
               end else begin
                  if (((d == 0) ? q0.size() : q1.size()) == 0) begin
                     chk($sformatf("d%0d_unexpected_completion", d), 32'd1, 32'd0);
                  end else begin
                     if (d == 0) e = q0.pop_front();
                     else        e = q1.pop_front();
                     chk($sformatf("d%0d_hresp", d), 32'(hresp[d]), 32'(e.err));
                     chk($sformatf("d%0d_wait_cycles", d), 32'(nlow_m[d]), 32'(e.nlow));
                     chk($sformatf("d%0d_stall_hresp", d), 32'(lores_m[d]),
                         32'((e.nlow != 4'd0) && e.err));
                     chk($sformatf("d%0d_hrdata", d), hrdata[d],
                         (e.rd && !e.err) ? e.rdata : 32'd0);
                  end
                  dph_m[d] = 1'b0;
               end
            end else begin
               chk($sformatf("d%0d_idle_hreadyout", d), 32'(hreadyout[d]), 32'd1);
               chk($sformatf("d%0d_idle_hresp", d), 32'(hresp[d]), 32'd0);
               chk($sformatf("d%0d_idle_hrdata", d), hrdata[d], 32'd0);
            end
            if (hselx[d] && hreadyout[d] && htrans[d][1]) begin
               dph_m[d]   = 1'b1;
               nlow_m[d]  = 4'd0;
               lores_m[d] = 1'b0;
            end
         end
      end
   end

   initial begin
      #50000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int d = 0; d < 2; d++) begin
         hresetn[d] = 1'b0;
         hselx[d]   = 1'b0;
         haddr[d]   = '0;
         htrans[d]  = HTRANS_IDLE;
         hwrite[d]  = 1'b0;
         hsize[d]   = '0;
         hwdata[d]  = '0;
         dph_m[d]   = 1'b0;
         nlow_m[d]  = 4'd0;
         lores_m[d] = 1'b0;
      end
      repeat (3) @(posedge hclk);
      #1;
      for (int d = 0; d < 2; d++) begin
         chk($sformatf("d%0d_rst_hreadyout", d), 32'(hreadyout[d]), 32'd1);
         chk($sformatf("d%0d_rst_hresp", d), 32'(hresp[d]), 32'd0);
         chk($sformatf("d%0d_rst_hrdata", d), hrdata[d], 32'd0);
      end
      hresetn[0] = 1'b1;
      hresetn[1] = 1'b1;
      @(posedge hclk);
      #1;

      // Zero wait states: back-to-back write/read, then byte-lane merging.
      xfer(0, 1, HTRANS_NONSEQ, 16'h0010, 1, HSIZE_WORD, 32'hDEADBEEF, 0, 32'h0);
      xfer(0, 1, HTRANS_NONSEQ, 16'h0010, 0, HSIZE_WORD, 32'h0,        0, 32'hDEADBEEF);
      xfer(0, 1, HTRANS_NONSEQ, 16'h0020, 1, HSIZE_WORD, 32'h11223344, 0, 32'h0);
      xfer(0, 1, HTRANS_NONSEQ, 16'h0022, 1, HSIZE_BYTE, 32'h55AA5555, 0, 32'h0);
      xfer(0, 1, HTRANS_NONSEQ, 16'h0020, 1, HSIZE_HALF, 32'h9999BBCC, 0, 32'h0);
      xfer(0, 1, HTRANS_NONSEQ, 16'h0020, 0, HSIZE_WORD, 32'h0,        0, 32'h11AABBCC);
      xfer(0, 1, HTRANS_NONSEQ, 16'h0000, 1, HSIZE_WORD, 32'hA5A5A5A5, 0, 32'h0);
      xfer(0, 1, HTRANS_SEQ,    16'h0024, 1, HSIZE_WORD, 32'h55667788, 0, 32'h0);
      xfer(0, 1, HTRANS_SEQ,    16'h0024, 0, HSIZE_WORD, 32'h0,        0, 32'h55667788);

      // Illegal accesses, then confirm nothing changed.
      xfer(0, 1, HTRANS_NONSEQ, 16'h1000, 0, HSIZE_WORD, 32'h0,        1, 32'h0);
      xfer(0, 1, HTRANS_NONSEQ, 16'h0002, 1, HSIZE_WORD, 32'hFFFFFFFF, 1, 32'h0);
      xfer(0, 1, HTRANS_NONSEQ, 16'h0010, 0, 3'd3,       32'h0,        1, 32'h0);
      xfer(0, 1, HTRANS_NONSEQ, 16'h0021, 1, HSIZE_HALF, 32'hFFFFFFFF, 1, 32'h0);
      xfer(0, 1, HTRANS_NONSEQ, 16'h0000, 0, HSIZE_WORD, 32'h0,        0, 32'hA5A5A5A5);
      xfer(0, 1, HTRANS_NONSEQ, 16'h0020, 0, HSIZE_WORD, 32'h0,        0, 32'h11AABBCC);

      // Non-transfers must not write.
      xfer(0, 1, HTRANS_IDLE,   16'h0010, 1, HSIZE_WORD, 32'h0BADF00D, 0, 32'h0);
      xfer(0, 1, HTRANS_BUSY,   16'h0010, 1, HSIZE_WORD, 32'h0BADF00D, 0, 32'h0);
      xfer(0, 0, HTRANS_NONSEQ, 16'h0010, 1, HSIZE_WORD, 32'h0BADF00D, 0, 32'h0);
      xfer(0, 1, HTRANS_NONSEQ, 16'h0010, 0, HSIZE_WORD, 32'h0,        0, 32'hDEADBEEF);
      idle(0);

      // Three wait states.
      xfer(1, 1, HTRANS_NONSEQ, 16'h0010, 1, HSIZE_WORD, 32'h01020304, 0, 32'h0);
      xfer(1, 1, HTRANS_NONSEQ, 16'h0010, 0, HSIZE_WORD, 32'h0,        0, 32'h01020304);
      xfer(1, 1, HTRANS_NONSEQ, 16'h1000, 0, HSIZE_WORD, 32'h0,        1, 32'h0);
      xfer(1, 1, HTRANS_NONSEQ, 16'h0030, 1, HSIZE_WORD, 32'h12345678, 0, 32'h0);
      idle(1);
      idle(1);

      // Reset in the middle of a waited write aborts it.
      hselx[1]  = 1'b1;
      htrans[1] = HTRANS_NONSEQ;
      haddr[1]  = 16'h0030;
      hwrite[1] = 1'b1;
      hsize[1]  = HSIZE_WORD;
      wait_accept(1);
      hwdata[1] = 32'hCAFEF00D;
      hselx[1]  = 1'b0;
      htrans[1] = HTRANS_IDLE;
      @(posedge hclk);
      #1;
      chk("d1_midwait_stalled", 32'(hreadyout[1]), 32'd0);
      hresetn[1] = 1'b0;
      #1;
      chk("d1_abort_hreadyout", 32'(hreadyout[1]), 32'd1);
      chk("d1_abort_hresp", 32'(hresp[1]), 32'd0);
      chk("d1_abort_hrdata", hrdata[1], 32'd0);
      @(posedge hclk);
      #1;
      hresetn[1] = 1'b1;
      @(posedge hclk);
      #1;
      xfer(1, 1, HTRANS_NONSEQ, 16'h0030, 0, HSIZE_WORD, 32'h0, 0, 32'h12345678);
      idle(1);

      for (int i = 0; i < 3; i++) begin
         idle(0);
         idle(1);
      end
      chk("d0_queue_drained", 32'(q0.size()), 32'd0);
      chk("d1_queue_drained", 32'(q1.size()), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/ahb_mem_slave.md
# ahb_mem_slave

AHB-Lite slave memory: the responder end of the AHB bus that the testbench driver initiates on. It decodes address/control phases, stalls with a programmable number of wait states, and performs byte-lane-accurate writes and reads to an internal word array. Illegal accesses get the standard two-cycle ERROR response. It sits behind the bus select decode and is the DUT for the memory environment.

## Interface
- ADDR_W, 16, haddr width (byte address)
- DATA_W, 32, data bus width; fixed at 32 for this block
- MEM_DEPTH, 1024, number of 32-bit words; legal byte range 0 to 4*MEM_DEPTH-1
- WAIT_STATES, 0, hreadyout-low cycles inserted per OKAY data phase (0–15)

Ports:
- hclk  in  1  bus clock; all logic on posedge
- hresetn  in  1  asynchronous active-low reset
- hselx  in  1  slave select
- haddr  in  ADDR_W  byte address (address phase)
- htrans  in  2  IDLE/BUSY/NONSEQ/SEQ
- hwrite  in  1  1 = write
- hsize  in  3  0 byte, 1 halfword, 2 word; others illegal
- hready  in  1  bus-level ready (previous transfer complete)
- hwdata  in  DATA_W  write data (data phase)
- hrdata  out  DATA_W  read data (data phase)
- hreadyout  out  1  slave ready
- hresp  out  1  0 OKAY, 1 ERROR

## Operation
- Transfer accepted on a posedge with hselx & hready & htrans[1]. IDLE/BUSY or hselx=0: no transfer, next cycle is zero-wait OKAY.
- Accepted address, hwrite and hsize are registered for the data phase.
- Illegal means: word index ≥ MEM_DEPTH; hsize > 2; halfword with haddr[0]=1; word with haddr[1:0]≠0.
- FSM states:
  - S_IDLE: hreadyout=1, hresp=0.
  - S_WAIT: counts down WAIT_STATES, hreadyout=0, hresp=0.
  - S_ERR1: hreadyout=0, hresp=1.
  - S_ERR2: hreadyout=1, hresp=1.
- Transitions:
  - Accept legal with WAIT_STATES=0 → stay S_IDLE; completes next cycle.
  - Accept legal with WAIT_STATES>0 → S_WAIT.
  - S_WAIT at count 0 → S_IDLE, with hreadyout=1 in that completing cycle.
  - Accept illegal → S_ERR1 → S_ERR2 → S_IDLE.
- Write: on the completing edge (hreadyout=1, OKAY), lanes are written per hsize and haddr[1:0], little-endian. Byte → lane haddr[1:0]; halfword → lanes {haddr[1],0}+1:0. Other lanes unchanged. ERROR transfers never write.
- Read: hrdata is the full 32-bit word at the registered word index during an OKAY read data phase. It is 0 otherwise, including during error and idle.
- A new address phase is accepted in the same cycle the current data phase completes; pipelining is back-to-back.

## Timing
- Reset (async assert, sync deassert on hclk): state S_IDLE, hreadyout=1, hresp=0, hrdata=0, wait counter 0, registered control cleared. Memory contents are not reset.
- Read latency: data is valid WAIT_STATES+1 cycles after the address-phase edge.
- A write followed immediately by a read of the same address returns the new data; the write commits before the read's data phase.
- During S_WAIT/S_ERR1 the master holds its next address phase (hready=0), and the slave accepts nothing.
- Reset mid-wait or mid-error aborts the transfer; no write occurs.
- hselx deasserting during a data phase does not abort it.

## Structure
- Shared package ahb_pkg holds:
  - htrans encodings (IDLE=2'b00, BUSY=2'b01, NONSEQ=2'b10, SEQ=2'b11)
  - hsize encodings
  - HRESP_OKAY/HRESP_ERROR
  - the slave state enum
- Sub-module ahb_mem_array: MEM_DEPTH×32 storage with 4-bit byte write enable and asynchronous read port.
- The top level contains the control FSM, wait counter, lane decoder and illegal-access check.

## Test plan
- WAIT_STATES=0: word write 0xDEADBEEF to 0x0010, then read 0x0010 back-to-back → hrdata=0xDEADBEEF on the second data phase; hreadyout never low.
- Byte lanes: word 0x11223344 at 0x0020, then byte write 0xAA at 0x0022, then halfword 0xBBCC at 0x0020 → read 0x0020 returns 0x11AABBCC.
- WAIT_STATES=3: read 0x0010 → hreadyout low exactly 3 cycles, then high with data.
- Out-of-range and misaligned accesses → hresp=1 for 2 cycles, hreadyout 0 then 1, memory unchanged. Cases: word read at 0x1000 (MEM_DEPTH=1024); word write at 0x0002; hsize=3.
- IDLE/BUSY htrans, or hselx=0 with NONSEQ → no write, hreadyout=1, hresp=0.
- hresetn pulsed low mid-wait of a write to 0x0030 → outputs return to reset values immediately, and a later read of 0x0030 shows the old contents.
